mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the team's single-port 256x8 synchronous RAM (write on clock edge, registered read address, one-cycle read latency) between two independent masters. Each master issues read/write requests over a valid/ready handshake. The arbiter drives the RAM port and routes read data back to the originating master with registered, fixed-latency responses.

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Grants one access per cycle and returns read data on a fixed 2-cycle pipeline.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          REQ0_VALID,
  input  logic          REQ0_WE,
  input  logic [AW-1:0] REQ0_ADDR,
  input  logic [DW-1:0] REQ0_WDATA,
  output logic          REQ0_READY,
  output logic          RSP0_VALID,
  output logic [DW-1:0] RSP0_RDATA,
  input  logic          REQ1_VALID,
  input  logic          REQ1_WE,
  input  logic [AW-1:0] REQ1_ADDR,
  input  logic [DW-1:0] REQ1_WDATA,
  output logic          REQ1_READY,
  output logic          RSP1_VALID,
  output logic [DW-1:0] RSP1_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_D,
  input  logic [DW-1:0] MEM_Q
);

  logic          gnt0;
  logic          gnt1;
  logic          last_q,       last_d;
  logic          rd_valid_q,   rd_valid_d;
  logic          rd_port_q,    rd_port_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;

  // last_q names the most recent winner; on contention the other port goes.
  always_comb begin
    gnt0 = REQ0_VALID & (~REQ1_VALID | last_q);
    gnt1 = REQ1_VALID & (~REQ0_VALID | ~last_q);
  end

  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;

  always_comb begin
    MEM_ADDR = '0;
    MEM_D    = '0;
    MEM_WE   = 1'b0;
    if (gnt0) begin
      MEM_ADDR = REQ0_ADDR;
      MEM_D    = REQ0_WDATA;
      MEM_WE   = REQ0_WE;
    end else if (gnt1) begin
      MEM_ADDR = REQ1_ADDR;
      MEM_D    = REQ1_WDATA;
      MEM_WE   = REQ1_WE;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end

    rd_valid_d = (gnt0 & ~REQ0_WE) | (gnt1 & ~REQ1_WE);
    rd_port_d  = gnt1;

    // MEM_Q is only meaningful the cycle after a read was presented.
    rsp0_valid_d = rd_valid_q & ~rd_port_q;
    rsp1_valid_d = rd_valid_q &  rd_port_q;
    rsp0_rdata_d = rsp0_valid_d ? MEM_Q : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? MEM_Q : rsp1_rdata_q;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      last_q       <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_port_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      last_q       <= last_d;
      rd_valid_q   <= rd_valid_d;
      rd_port_q    <= rd_port_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign RSP0_VALID = rsp0_valid_q;
  assign RSP1_VALID = rsp1_valid_q;
  assign RSP0_RDATA = rsp0_rdata_q;
  assign RSP1_RDATA = rsp1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a 256x8 synchronous RAM model
// and a reference memory / grant model.
module tb_mem_arbiter;

  logic       CLK;
  logic       RST_X;
  logic       REQ0_VALID, REQ0_WE, REQ0_READY, RSP0_VALID;
  logic [7:0] REQ0_ADDR, REQ0_WDATA, RSP0_RDATA;
  logic       REQ1_VALID, REQ1_WE, REQ1_READY, RSP1_VALID;
  logic [7:0] REQ1_ADDR, REQ1_WDATA, RSP1_RDATA;
  logic [7:0] MEM_ADDR, MEM_D, MEM_Q;
  logic       MEM_WE;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .REQ0_VALID(REQ0_VALID), .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_READY(REQ0_READY),
    .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_READY(REQ1_READY),
    .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_D(MEM_D), .MEM_Q(MEM_Q)
  );

  // single-port RAM: write on edge, registered read address
  logic [7:0] ram [0:255];
  logic [7:0] ram_ra;
  always @(posedge CLK) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_D;
    ram_ra <= MEM_ADDR;
  end
  assign MEM_Q = ram[ram_ra];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // requesters must hold their request stable while stalled
  a_hold0: assert property (@(posedge CLK) disable iff (!RST_X)
    (REQ0_VALID && !REQ0_READY) |=> (REQ0_VALID && $stable(REQ0_WE) &&
                                     $stable(REQ0_ADDR) && $stable(REQ0_WDATA)));
  a_hold1: assert property (@(posedge CLK) disable iff (!RST_X)
    (REQ1_VALID && !REQ1_READY) |=> (REQ1_VALID && $stable(REQ1_WE) &&
                                     $stable(REQ1_ADDR) && $stable(REQ1_WDATA)));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      REQ0_VALID = v; REQ0_WE = we; REQ0_ADDR = a; REQ0_WDATA = d;
    end else begin
      REQ1_VALID = v; REQ1_WE = we; REQ1_ADDR = a; REQ1_WDATA = d;
    end
  endtask

  logic [7:0] ref_mem [0:255];
  int         q_due[$];
  bit         q_port[$];
  logic [7:0] q_data[$];

  initial begin
    logic       pv [2];
    logic       pwe[2];
    logic [7:0] pa [2];
    logic [7:0] pd [2];
    logic       gprev[2];
    logic       er0, er1, ev0, ev1, last_m;
    int         wait0, wait1, xfers, cyc;

    RST_X = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    #2;
    chk("rst_rsp0_valid", RSP0_VALID, 0);
    chk("rst_rsp1_valid", RSP1_VALID, 0);
    chk("rst_rsp0_rdata", RSP0_RDATA, 0);
    chk("rst_rsp1_rdata", RSP1_RDATA, 0);
    tick(); tick();
    RST_X = 1'b1;

    // single port: write A5 to 0x10, read it back next cycle
    drive(0, 1, 1, 8'h10, 8'hA5);
    #1;
    chk("sp_wr_ready0", REQ0_READY, 1);
    chk("sp_wr_ready1", REQ1_READY, 0);
    chk("sp_wr_mem_we", MEM_WE, 1);
    chk("sp_wr_mem_addr", MEM_ADDR, 8'h10);
    chk("sp_wr_mem_d", MEM_D, 8'hA5);
    tick();
    drive(0, 1, 0, 8'h10, 8'h00);
    #1;
    chk("sp_rd_ready0", REQ0_READY, 1);
    chk("sp_rd_mem_we", MEM_WE, 0);
    chk("sp_rd_mem_addr", MEM_ADDR, 8'h10);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("sp_idle_ready0", REQ0_READY, 0);
    chk("sp_idle_mem_addr", MEM_ADDR, 0);
    chk("sp_n2_rsp0_valid", RSP0_VALID, 0);
    tick();
    #1;
    chk("sp_n3_rsp0_valid", RSP0_VALID, 1);
    chk("sp_n3_rsp0_rdata", RSP0_RDATA, 8'hA5);
    chk("sp_n3_rsp1_valid", RSP1_VALID, 0);
    tick();
    #1;
    chk("sp_n4_rsp0_valid", RSP0_VALID, 0);

    // preload 0x01=0x11 via port 0, 0x02=0x22 via port 1 (leaves last = 1)
    drive(0, 1, 1, 8'h01, 8'h11);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 1, 1, 8'h02, 8'h22);
    #1;
    chk("pre_ready1", REQ1_READY, 1);
    tick();
    drive(1, 0, 0, 8'h00, 8'h00);

    // contention: both hold reads; grants alternate starting with port 0
    for (int i = 0; i <= 10; i++) begin
      drive(0, (i <= 8), 0, 8'h01, 8'h00);
      drive(1, (i <= 7), 0, 8'h02, 8'h00);
      #1;
      chk($sformatf("ct%0d_ready0", i), REQ0_READY, (i <= 8) && (i % 2 == 0));
      chk($sformatf("ct%0d_ready1", i), REQ1_READY, (i <= 7) && (i % 2 == 1));
      chk($sformatf("ct%0d_rsp0_valid", i), RSP0_VALID, (i >= 2) && (i % 2 == 0));
      chk($sformatf("ct%0d_rsp1_valid", i), RSP1_VALID, (i >= 3) && (i <= 9) && (i % 2 == 1));
      if (i >= 2 && i % 2 == 0) chk($sformatf("ct%0d_rsp0_rdata", i), RSP0_RDATA, 8'h11);
      if (i >= 3 && i % 2 == 1) chk($sformatf("ct%0d_rsp1_rdata", i), RSP1_RDATA, 8'h22);
      tick();
    end

    // reset with a read in flight: outputs clear at once, read is dropped
    drive(0, 1, 0, 8'h02, 8'h00);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    #1;
    RST_X = 1'b0;
    #1;
    chk("ra_rsp0_valid", RSP0_VALID, 0);
    chk("ra_rsp0_rdata", RSP0_RDATA, 0);
    chk("ra_rsp1_rdata", RSP1_RDATA, 0);
    drive(0, 1, 0, 8'h05, 8'h00);
    drive(1, 1, 0, 8'h06, 8'h00);
    #1;
    chk("ra_ready0", REQ0_READY, 1);
    chk("ra_ready1", REQ1_READY, 0);
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    tick(); tick();
    RST_X = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rr%0d_rsp0_valid", i), RSP0_VALID, 0);
      chk($sformatf("rr%0d_rsp1_valid", i), RSP1_VALID, 0);
      tick();
    end

    // mixed: port 0 writes 0x3C to 0xFF while port 1 reads 0xFF
    drive(0, 1, 1, 8'hFF, 8'h3C);
    drive(1, 1, 0, 8'hFF, 8'h00);
    #1;
    chk("mx_c0_ready0", REQ0_READY, 1);
    chk("mx_c0_ready1", REQ1_READY, 0);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("mx_c1_ready1", REQ1_READY, 1);
    chk("mx_c1_mem_addr", MEM_ADDR, 8'hFF);
    chk("mx_c1_mem_we", MEM_WE, 0);
    tick();
    drive(1, 0, 0, 8'h00, 8'h00);
    #1;
    chk("mx_c2_rsp1_valid", RSP1_VALID, 0);
    tick();
    #1;
    chk("mx_c3_rsp1_valid", RSP1_VALID, 1);
    chk("mx_c3_rsp1_rdata", RSP1_RDATA, 8'h3C);
    chk("mx_c3_rsp0_valid", RSP0_VALID, 0);
    tick();

    // fill the whole RAM through port 0 so the reference model is complete
    for (int a = 0; a < 256; a++) begin
      drive(0, 1, 1, 8'(a), 8'(a) ^ 8'h5A);
      ref_mem[a] = 8'(a) ^ 8'h5A;
      tick();
    end
    drive(0, 0, 0, 8'h00, 8'h00);
    last_m = 1'b0;

    // random phase with reference memory and grant model
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; pwe[p] = 0; pa[p] = 0; pd[p] = 0; gprev[p] = 1;
    end
    wait0 = 0; wait1 = 0; xfers = 0; cyc = 0;
    while (cyc < 40000 && (xfers < 10000 || q_due.size() != 0 || pv[0] || pv[1])) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] || gprev[p]) begin
          pv[p]  = (xfers < 10000) && ($urandom_range(0, 9) < 7);
          pwe[p] = $urandom_range(0, 2) == 0;
          pa[p]  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
          pd[p]  = 8'($urandom);
        end
        drive(p, pv[p], pwe[p], pa[p], pd[p]);
      end
      #1;
      er0 = pv[0] & (~pv[1] | last_m);
      er1 = pv[1] & (~pv[0] | ~last_m);
      chk("rnd_ready0", REQ0_READY, er0);
      chk("rnd_ready1", REQ1_READY, er1);

      ev0 = (q_due.size() != 0) && (q_due[0] == cyc) && (q_port[0] == 0);
      ev1 = (q_due.size() != 0) && (q_due[0] == cyc) && (q_port[0] == 1);
      chk("rnd_rsp0_valid", RSP0_VALID, ev0);
      chk("rnd_rsp1_valid", RSP1_VALID, ev1);
      if (ev0) chk($sformatf("rnd_rsp0_rdata@%0d", cyc), RSP0_RDATA, q_data[0]);
      if (ev1) chk($sformatf("rnd_rsp1_rdata@%0d", cyc), RSP1_RDATA, q_data[0]);
      if (ev0 || ev1) begin
        void'(q_due.pop_front()); void'(q_port.pop_front()); void'(q_data.pop_front());
      end

      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? er0 : er1) begin
          xfers++;
          last_m = 1'(p);
          if (pwe[p]) ref_mem[pa[p]] = pd[p];
          else begin
            q_due.push_back(cyc + 2); q_port.push_back(1'(p)); q_data.push_back(ref_mem[pa[p]]);
          end
        end
      end
      wait0 = (pv[0] && !er0) ? wait0 + 1 : 0;
      wait1 = (pv[1] && !er1) ? wait1 + 1 : 0;
      if (wait0 != 0) chk("rnd_wait0_le1", (wait0 <= 1), 1);
      if (wait1 != 0) chk("rnd_wait1_le1", (wait1 <= 1), 1);
      gprev[0] = er0;
      gprev[1] = er1;
      if (pv[0] && er0) pv[0] = (xfers < 10000) ? pv[0] : 1'b0;
      if (pv[1] && er1) pv[1] = (xfers < 10000) ? pv[1] : 1'b0;
      cyc++;
      tick();
    end
    chk("rnd_xfer_budget", (xfers >= 10000), 1);
    chk("rnd_queue_drained", q_due.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
